fetch_queue: RTL and testbench

//  Decoupling FIFO between the IF stage and the ID stage.
//  - Accepts one fetched instruction per cycle from IF: pc, inst, predicted-taken bit and PHT index.
//  - Presents the oldest entry to ID through a valid/ready handshake.
//  - Absorbs ID/IDROB back-pressure so IF can keep fetching.
//  - On a branch-mispredict or exception flush, all queued (wrong-path) instructions are discarded.

---
 rtl/fetch_queue_pkg.sv | 8 +
 rtl/fetch_queue_ram.sv | 28 ++
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared field widths for the IF->ID fetch queue datapath.
package fetch_queue_pkg;

   localparam int ADDR_W = 32;  // program-counter width
   localparam int INST_W = 32;  // instruction word width
   localparam int GHR_W  = 8;   // PHT index width (global history)

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH x WIDTH register array,
// one synchronous write port and one asynchronous read port. Contents are
// never reset; validity is tracked entirely by the pointers in the parent.
module fetch_queue_ram #(
   parameter int DEPTH     = 8,
   parameter int PTR_WIDTH = 3,
   parameter int WIDTH     = 73
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [PTR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [PTR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the addressed entry on an accepted push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between IF and ID. IF pushes one fetched instruction per
// cycle; ID pops the oldest entry over a valid/ready handshake. A flush
// (mispredict or exception) empties the queue in one cycle by snapping the
// write pointer onto the read pointer.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int PTR_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 push_valid,
   output logic                 push_ready,
   input  logic [ADDR_W-1:0]    pc_in,
   input  logic [INST_W-1:0]    inst_in,
   input  logic                 is_branch_taken_in,
   input  logic [GHR_W-1:0]     pht_index_in,
   output logic                 pop_valid,
   input  logic                 pop_ready,
   output logic [ADDR_W-1:0]    pc_out,
   output logic [INST_W-1:0]    inst_out,
   output logic                 is_branch_taken_out,
   output logic [GHR_W-1:0]     pht_index_out,
   output logic [PTR_WIDTH:0]   count
);

   // Entry packing: {is_branch_taken, pht_index, pc, inst}
   localparam int ENTRY_W = 1 + GHR_W + ADDR_W + INST_W;
   localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

   logic [PTR_WIDTH-1:0] wptr;
   logic [PTR_WIDTH-1:0] rptr;
   logic                 do_push;
   logic                 do_pop;
   logic                 we;
   logic [ENTRY_W-1:0]   wdata;
   logic [ENTRY_W-1:0]   rdata;

   assign pop_valid = (count != '0);

   // A full queue still accepts when the head leaves this cycle; during a
   // flush IF is never stalled (its push is simply dropped).
   assign push_ready = flush | (count != FULL_COUNT) | (pop_valid & pop_ready);

   assign do_push = push_valid & push_ready;
   assign do_pop  = pop_valid & pop_ready;

   // Flush and reset both drop the same-cycle push, so keep it out of storage.
   assign we    = do_push & ~flush & ~rst;
   assign wdata = {is_branch_taken_in, pht_index_in, pc_in, inst_in};

   fetch_queue_ram #(
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH),
      .WIDTH     (ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wptr),
      .wdata (wdata),
      .raddr (rptr),
      .rdata (rdata)
   );

   // Head entry is presented combinationally; an empty queue shows all zeros (NOP).
   assign {is_branch_taken_out, pht_index_out, pc_out, inst_out} =
      pop_valid ? rdata : '0;

   // Pointer and occupancy update: reset, then flush, then push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= rptr;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based model.
module tb_fetch_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, flush, push_valid, push_ready, pop_valid, pop_ready;
   logic [31:0] pc_in, inst_in, pc_out, inst_out;
   logic        is_branch_taken_in, is_branch_taken_out;
   logic [7:0]  pht_index_in, pht_index_out;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(8), .PTR_WIDTH(3)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .push_valid          (push_valid),
      .push_ready          (push_ready),
      .pc_in               (pc_in),
      .inst_in             (inst_in),
      .is_branch_taken_in  (is_branch_taken_in),
      .pht_index_in        (pht_index_in),
      .pop_valid           (pop_valid),
      .pop_ready           (pop_ready),
      .pc_out              (pc_out),
      .inst_out            (inst_out),
      .is_branch_taken_out (is_branch_taken_out),
      .pht_index_out       (pht_index_out),
      .count               (count)
   );

   // Reference model: the queue content as a plain list, oldest first.
   typedef struct packed {
      logic        taken;
      logic [7:0]  pht;
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t mq[$];
   logic exp_pv, exp_pr;
   ent_t exp_head;
   logic cur_rst, cur_flush, cur_pv, cur_pr;
   ent_t cur_ent;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Occupancy must stay within 0..DEPTH (an underflow would wrap above DEPTH).
   always @(negedge clk) begin
      if (started) begin
         checks++;
         assert (count <= 4'(DEPTH)) else begin
            errors++;
            $display("FAIL count_range actual=%0d required<=%0d", count, DEPTH);
         end
      end
   end

   // Drive one cycle of inputs and compare every output against the model.
   task automatic begin_cycle(input logic r, input logic f, input logic pv, input logic pr,
                              input logic [31:0] p, input logic [31:0] i,
                              input logic t, input logic [7:0] h);
      @(negedge clk);
      rst = r; flush = f; push_valid = pv; pop_ready = pr;
      pc_in = p; inst_in = i; is_branch_taken_in = t; pht_index_in = h;
      cur_rst = r; cur_flush = f; cur_pv = pv; cur_pr = pr;
      cur_ent = '{taken: t, pht: h, pc: p, inst: i};
      #1;
      exp_pv   = (mq.size() != 0);
      exp_head = exp_pv ? mq[0] : '0;
      exp_pr   = f || (mq.size() != DEPTH) || (exp_pv && pr);
      check("pop_valid",  64'(pop_valid),           64'(exp_pv));
      check("push_ready", 64'(push_ready),          64'(exp_pr));
      check("count",      64'(count),               64'(mq.size()));
      check("pc_out",     64'(pc_out),              64'(exp_head.pc));
      check("inst_out",   64'(inst_out),            64'(exp_head.inst));
      check("taken_out",  64'(is_branch_taken_out), 64'(exp_head.taken));
      check("pht_out",    64'(pht_index_out),       64'(exp_head.pht));
   endtask

   // Let the clock edge happen and advance the model by the same rules.
   task automatic end_cycle();
      @(posedge clk);
      if (cur_rst || cur_flush) begin
         mq.delete();
      end else begin
         if (exp_pv && cur_pr) void'(mq.pop_front());
         if (cur_pv && exp_pr) mq.push_back(cur_ent);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic pv, input logic pr,
                       input logic [31:0] p, input logic [31:0] i,
                       input logic t, input logic [7:0] h);
      begin_cycle(r, f, pv, pr, p, i, t, h);
      end_cycle();
   endtask

   typedef struct {
      logic        pv, pr;
      logic [31:0] pc, inst;
      logic [3:0]  cnt;
      logic        pvld, prdy;
      logic [31:0] pco, insto;
   } vec_t;

   vec_t tbl[7];

   initial begin
      rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
      pc_in = '0; inst_in = '0; is_branch_taken_in = 1'b0; pht_index_in = '0;
      repeat (2) @(posedge clk);
      started = 1;

      // Reset/idle, then two pushes held, then drained in order.
      tbl[0] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'd0, 1'b0, 1'b1, 32'h0,        32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'hbfc00000, 32'h90001234, 4'd0, 1'b0, 1'b1, 32'h0,        32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'hbfc00004, 32'hac001234, 4'd1, 1'b1, 1'b1, 32'hbfc00000, 32'h90001234};
      tbl[3] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'd2, 1'b1, 1'b1, 32'hbfc00000, 32'h90001234};
      tbl[4] = '{1'b0, 1'b1, 32'h0,        32'h0,        4'd2, 1'b1, 1'b1, 32'hbfc00000, 32'h90001234};
      tbl[5] = '{1'b0, 1'b1, 32'h0,        32'h0,        4'd1, 1'b1, 1'b1, 32'hbfc00004, 32'hac001234};
      tbl[6] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'd0, 1'b0, 1'b1, 32'h0,        32'h0};
      for (int k = 0; k < 7; k++) begin
         begin_cycle(1'b0, 1'b0, tbl[k].pv, tbl[k].pr, tbl[k].pc, tbl[k].inst, 1'b0, 8'h00);
         check("tbl_count",  64'(count),      64'(tbl[k].cnt));
         check("tbl_pvalid", 64'(pop_valid),  64'(tbl[k].pvld));
         check("tbl_pready", 64'(push_ready), 64'(tbl[k].prdy));
         check("tbl_pc",     64'(pc_out),     64'(tbl[k].pco));
         check("tbl_inst",   64'(inst_out),   64'(tbl[k].insto));
         end_cycle();
      end

      // Fill to full, hold a 9th push, then push+pop while full.
      for (int k = 0; k < 8; k++)
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc10000 + 32'(4 * k), 32'h1000 + 32'(k), k[0], 8'(k));
      begin_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hdead0000, 32'hdeadbeef, 1'b1, 8'hff);
      check("full_count", 64'(count),      64'd8);
      check("full_ready", 64'(push_ready), 64'd0);
      end_cycle();
      begin_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc10020, 32'h1008, 1'b0, 8'h08);
      check("fullpp_ready", 64'(push_ready), 64'd1);
      check("fullpp_head",  64'(pc_out),     64'hbfc10000);
      end_cycle();
      begin_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      check("fullpp_count", 64'(count),  64'd8);
      check("fullpp_next",  64'(pc_out), 64'hbfc10004);
      end_cycle();
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 8'h00);

      // Streaming push+pop across pointer wrap.
      for (int k = 0; k < 20; k++) begin
         begin_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc00000 + 32'(4 * k), 32'(k), 1'b0, 8'(k));
         if (k > 0) begin
            check("stream_count", 64'(count),  64'd1);
            check("stream_pc",    64'(pc_out), 64'(32'hbfc00000 + 32'(4 * (k - 1))));
         end
         end_cycle();
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 8'h00);

      // Flush with simultaneous push and pop, then 1-cycle refill latency.
      for (int k = 0; k < 5; k++)
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc30000 + 32'(4 * k), 32'(k), 1'b1, 8'(k));
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'hcafe0000, 32'hcafe, 1'b1, 8'h55);
      begin_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc20000, 32'h20, 1'b1, 8'h21);
      check("flush_count",  64'(count),     64'd0);
      check("flush_pvalid", 64'(pop_valid), 64'd0);
      check("flush_pc",     64'(pc_out),    64'd0);
      end_cycle();
      begin_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      check("refill_pvalid", 64'(pop_valid), 64'd1);
      check("refill_pc",     64'(pc_out),    64'hbfc20000);
      check("refill_count",  64'(count),     64'd1);
      end_cycle();

      // Reset while busy.
      for (int k = 0; k < 5; k++)
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc40000 + 32'(4 * k), 32'h4000 + 32'(k), 1'b1, 8'hc0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'hbfc50000, 32'h5000, 1'b1, 8'h77);
      begin_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      check("rst_count",  64'(count),               64'd0);
      check("rst_pvalid", 64'(pop_valid),           64'd0);
      check("rst_pc",     64'(pc_out),              64'd0);
      check("rst_inst",   64'(inst_out),            64'd0);
      check("rst_taken",  64'(is_branch_taken_out), 64'd0);
      check("rst_pht",    64'(pht_index_out),       64'd0);
      end_cycle();

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55,
              $urandom, $urandom, 1'($urandom), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
